// File: rtl/cond_logic.sv
// Conditional-execution unit: evaluates the condition field against the registered
// NZCV flags, gates the decoder write enables and counts squashed instructions.
module cond_logic (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cond,
  input  logic [3:0]  aluFlags,
  input  logic [1:0]  flagW,
  input  logic        pcs,
  input  logic        regW,
  input  logic        memW,
  input  logic        noWrite,
  input  logic        valid,
  input  logic        stall,
  input  logic        clrCount,
  output logic        pcSrc,
  output logic        regWrite,
  output logic        memWrite,
  output logic        condEx,
  output logic [3:0]  flags,
  output logic [15:0] skipCount
);

  logic n, z, c, v;
  logic go;
  logic skip;

  assign {n, z, c, v} = flags;

  always_comb begin
    condEx = 1'b0;
    case (cond)
      4'b0000: condEx = z;
      4'b0001: condEx = ~z;
      4'b0010: condEx = c;
      4'b0011: condEx = ~c;
      4'b0100: condEx = n;
      4'b0101: condEx = ~n;
      4'b0110: condEx = v;
      4'b0111: condEx = ~v;
      4'b1000: condEx = c & ~z;
      4'b1001: condEx = ~c | z;
      4'b1010: condEx = (n == v);
      4'b1011: condEx = (n != v);
      4'b1100: condEx = ~z & (n == v);
      4'b1101: condEx = z | (n != v);
      4'b1110: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end

  assign go   = valid & ~stall & condEx;
  assign skip = valid & ~stall & ~condEx;

  assign pcSrc    = pcs & go;
  assign regWrite = regW & go & ~noWrite;
  assign memWrite = memW & go;

  // Each flag half is written independently; unselected halves hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= '0;
    end else if (go) begin
      if (flagW[1]) flags[3:2] <= aluFlags[3:2];
      if (flagW[0]) flags[1:0] <= aluFlags[1:0];
    end
  end

  // Clear has priority over stall and increment; count saturates at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skipCount <= '0;
    end else if (clrCount) begin
      skipCount <= '0;
    end else if (skip && (skipCount != '1)) begin
      skipCount <= skipCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// Directed-vector bench for cond_logic with hand-computed expected values.
module tb_cond_logic;

  logic        clk;
  logic        reset;
  logic [3:0]  cond;
  logic [3:0]  aluFlags;
  logic [1:0]  flagW;
  logic        pcs, regW, memW, noWrite, valid, stall, clrCount;
  logic        pcSrc, regWrite, memWrite, condEx;
  logic [3:0]  flags;
  logic [15:0] skipCount;

  int unsigned n_tests;
  int unsigned n_fail;

  cond_logic dut (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .aluFlags  (aluFlags),
    .flagW     (flagW),
    .pcs       (pcs),
    .regW      (regW),
    .memW      (memW),
    .noWrite   (noWrite),
    .valid     (valid),
    .stall     (stall),
    .clrCount  (clrCount),
    .pcSrc     (pcSrc),
    .regWrite  (regWrite),
    .memWrite  (memWrite),
    .condEx    (condEx),
    .flags     (flags),
    .skipCount (skipCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0;
    cond = 4'b0000; aluFlags = 4'b0000; flagW = 2'b00;
    pcs = 1'b0; regW = 1'b0; memW = 1'b0; noWrite = 1'b0;
    valid = 1'b0; stall = 1'b0; clrCount = 1'b0;

    // Reset state, visible before any clock edge
    #2;
    check("rst_flags", {12'h0, flags}, 16'h0000);
    check("rst_skip", skipCount, 16'h0000);

    // Write enables stay combinational during reset (flags = 0)
    cond = 4'b1110; valid = 1'b1; pcs = 1'b1; settle();
    check("rst_pcsrc_al", {15'h0, pcSrc}, 16'h0001);
    cond = 4'b0001; settle();
    check("rst_condex_ne", {15'h0, condEx}, 16'h0001);
    cond = 4'b0000; settle();
    check("rst_condex_eq", {15'h0, condEx}, 16'h0000);
    step();
    check("rst_hold_skip", skipCount, 16'h0000);
    pcs = 1'b0; valid = 1'b0;
    reset = 1'b1;

    // EQ with Z=0 fails: squash and count
    cond = 4'b0000; valid = 1'b1; regW = 1'b1; settle();
    check("eq_condex", {15'h0, condEx}, 16'h0000);
    check("eq_regwrite", {15'h0, regWrite}, 16'h0000);
    step();
    check("eq_skip", skipCount, 16'h0001);

    // AL with full flag update; same-cycle aluFlags must not matter
    regW = 1'b0; cond = 4'b1110; flagW = 2'b11; aluFlags = 4'b0100; settle();
    check("al_condex", {15'h0, condEx}, 16'h0001);
    check("al_flags_pre", {12'h0, flags}, 16'h0000);
    step();
    check("al_flags_post", {12'h0, flags}, 16'h0004);
    flagW = 2'b00; cond = 4'b0000; memW = 1'b1; settle();
    check("eq_memwrite", {15'h0, memWrite}, 16'h0001);

    // Load flags = 1001 (N=1, V=1) and exercise signed conditions
    memW = 1'b0; cond = 4'b1110; flagW = 2'b11; aluFlags = 4'b1001;
    step();
    flagW = 2'b00;
    check("flags_1001", {12'h0, flags}, 16'h0009);
    cond = 4'b1010; settle(); check("ge_condex", {15'h0, condEx}, 16'h0001);
    cond = 4'b1011; settle(); check("lt_condex", {15'h0, condEx}, 16'h0000);
    cond = 4'b1100; settle(); check("gt_condex", {15'h0, condEx}, 16'h0001);
    cond = 4'b1101; settle(); check("le_condex", {15'h0, condEx}, 16'h0000);
    cond = 4'b1000; settle(); check("hi_condex", {15'h0, condEx}, 16'h0000);
    cond = 4'b1001; settle(); check("ls_condex", {15'h0, condEx}, 16'h0001);
    cond = 4'b0110; settle(); check("vs_condex", {15'h0, condEx}, 16'h0001);
    cond = 4'b1111; settle(); check("rsv_condex", {15'h0, condEx}, 16'h0000);
    cond = 4'b1110; regW = 1'b1; noWrite = 1'b1; settle();
    check("nowrite_regwrite", {15'h0, regWrite}, 16'h0000);
    noWrite = 1'b0; settle();
    check("al_regwrite", {15'h0, regWrite}, 16'h0001);
    regW = 1'b0;

    // Partial update: only N,Z written
    flagW = 2'b11; aluFlags = 4'b0000; step();
    check("flags_zero", {12'h0, flags}, 16'h0000);
    flagW = 2'b10; aluFlags = 4'b1111; step();
    check("flags_nz_only", {12'h0, flags}, 16'h000C);
    flagW = 2'b01; aluFlags = 4'b0001; step();
    check("flags_cv_only", {12'h0, flags}, 16'h000D);

    // Stall freezes flags and count, and blocks write enables
    stall = 1'b1; pcs = 1'b1; flagW = 2'b11; aluFlags = 4'b0010; settle();
    check("stall_pcsrc", {15'h0, pcSrc}, 16'h0000);
    step();
    check("stall_flags", {12'h0, flags}, 16'h000D);
    cond = 4'b0001; flagW = 2'b00; step();   // NE fails since Z=1
    check("stall_skip", skipCount, 16'h0001);

    // Bubble: no enables, no count, no flag update
    stall = 1'b0; valid = 1'b0; settle();
    check("bubble_pcsrc", {15'h0, pcSrc}, 16'h0000);
    step();
    check("bubble_skip", skipCount, 16'h0001);
    cond = 4'b1110; flagW = 2'b11; aluFlags = 4'b0000; step();
    check("bubble_flags", {12'h0, flags}, 16'h000D);
    pcs = 1'b0; flagW = 2'b00;

    // Clear wins over stall
    clrCount = 1'b1; stall = 1'b1; step();
    check("clr_stall", skipCount, 16'h0000);
    clrCount = 1'b0; stall = 1'b0;

    // Saturation: 65534 failing cycles reach FFFE, then hold at FFFF
    valid = 1'b1; cond = 4'b0001;
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
    end
    #1;
    check("sat_fffe", skipCount, 16'hFFFE);
    step(); check("sat_1", skipCount, 16'hFFFF);
    step(); check("sat_2", skipCount, 16'hFFFF);
    step(); check("sat_3", skipCount, 16'hFFFF);
    clrCount = 1'b1; step();
    check("clr_vs_inc", skipCount, 16'h0000);
    clrCount = 1'b0;

    // Mid-cycle reset discards the pending update and increment
    cond = 4'b1110; flagW = 2'b11; aluFlags = 4'b0110; #2;
    reset = 1'b0; #1;
    check("midrst_flags", {12'h0, flags}, 16'h0000);
    step();
    check("midrst_flags_edge", {12'h0, flags}, 16'h0000);
    reset = 1'b1;
    // First edge after release is a normal cycle
    step();
    check("post_rst_flags", {12'h0, flags}, 16'h0006);
    cond = 4'b0000; flagW = 2'b00; step();  // EQ with Z=1 passes, no skip
    check("post_rst_skip", skipCount, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 reset  input  1  Asynchronous, active-low reset; asserts immediately and is released synchronously to clk.
REQ-004 cond  input  4  Instruction condition field, bits [31:28].
REQ-005 aluFlags  input  4  ALU result flags {N,Z,C,V} for the current instruction.
REQ-006 flagW  input  2  From the decoder: [1] = update N,Z; [0] = update C,V.
REQ-007 pcs, regW, memW  input  1 each  Unconditional PC-write, register-write and memory-write requests from the decoder.
REQ-008 noWrite  input  1  Compare-class instruction; suppresses the register write.
REQ-009 valid  input  1  The current instruction is real; when low, the slot is a bubble.
REQ-010 stall  input  1  Freezes all state this cycle.
REQ-011 clrCount  input  1  Synchronous clear of skipCount.
REQ-012 pcSrc, regWrite, memWrite  output  1 each  Condition-gated write enables.
REQ-013 condEx  output  1  The condition passes against the registered flags.
REQ-014 flags  output  4  Registered {N,Z,C,V}.
REQ-015 skipCount  output  16  Count of squashed, valid, non-stalled instructions.

Function
REQ-016 condEx shall be combinational from cond and the registered flags, with one row per cond value:
- 0000 EQ: Z
- 0001 NE: ~Z
- 0010 CS: C
- 0011 CC: ~C
- 0100 MI: N
- 0101 PL: ~N
- 0110 VS: V
- 0111 VC: ~V
- 1000 HI: C&~Z
- 1001 LS: ~C|Z
- 1010 GE: N==V
- 1011 LT: N!=V
- 1100 GT: ~Z&(N==V)
- 1101 LE: Z|(N!=V)
- 1110 AL: 1
- 1111: reserved, 0
REQ-017 Let go = valid & ~stall & condEx.
REQ-018 The write enables shall be:
- pcSrc = pcs & go.
- regWrite = regW & go & ~noWrite.
- memWrite = memW & go.
REQ-019 The write enables shall be combinational, with zero latency.
REQ-020 Condition evaluation shall use the flags registered before the current edge; aluFlags of the same instruction shall never affect that instruction's condEx.
REQ-021 On a rising edge with go=1 and flagW[1]=1, flags[3:2] <= aluFlags[3:2].
REQ-022 On a rising edge with go=1 and flagW[0]=1, flags[1:0] <= aluFlags[1:0].
REQ-023 Each flag half not selected by flagW shall hold its value.
REQ-024 When go=0, flags shall hold; this covers a failed condition, a bubble and a stall.
REQ-025 The new flags shall be visible on flags and used by condEx from the cycle after the update.
REQ-026 skipCount shall increment by 1 on an edge where valid & ~stall & ~condEx.
REQ-027 skipCount shall saturate at 16'hFFFF with no wrap-around.
REQ-028 When clrCount=1, skipCount <= 0 on the edge, regardless of stall or a simultaneous increment; clear wins.
REQ-029 stall=1 shall hold flags and skipCount (except under clrCount) and force all three write enables to 0.
REQ-030 valid=0 shall force all three write enables to 0, and the bubble shall not count as a skip.
REQ-031 No output shall be X when all inputs are known.

Reset
REQ-032 While reset=0: flags=4'b0000, skipCount=16'h0000, regardless of clk.
REQ-033 During reset, the write enables shall follow their combinational equations using flags=0.
REQ-034 Reset asserted mid-operation shall discard any pending flag update and any pending counter increment.
REQ-035 The first edge after reset is released shall behave as a normal cycle.

Verification
REQ-036 Reset, then cond=0000 (EQ), valid=1, regW=1 -> condEx=0, regWrite=0; skipCount=1 after the edge.
REQ-037 cond=1110, flagW=2'b11, aluFlags=4'b0100, go -> flags=4'b0100 next cycle; then cond=0000, memW=1 -> memWrite=1.
REQ-038 flags=4'b1001, cond=1010 (GE) -> condEx=1; cond=1011 (LT) -> condEx=0; cond=1100 with Z=0 -> condEx=1.
REQ-039 flagW=2'b10, aluFlags=4'b1111, starting from flags=4'b0000 -> flags=4'b1100 (C,V held).
REQ-040 stall=1 with cond=1110, pcs=1, flagW=2'b11 -> pcSrc=0 and flags unchanged; failed condition with stall=1 -> skipCount unchanged.
REQ-041 skipCount=16'hFFFE, three failed-condition cycles -> FFFF, FFFF, FFFF; clrCount=1 together with a failing condition -> 0.
